// File: rtl/debug_cmd_bridge.sv
// debug_cmd_bridge
// Parses a host byte stream into single debug register bus accesses and
// returns an ACK, a NAK or the read data on a transmit byte stream.
//
// Commands:
//   write : 0x57, addr, data_lo, data_hi  -> 0x06
//   read  : 0x52, addr                    -> data_lo, data_hi
//   other opcode, or bus timeout          -> 0x15
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   rx_data, rx_valid   incoming byte, one-cycle valid pulse
//   tx_data, tx_valid   outgoing byte, held until tx_ready
//   tx_ready            transmitter accepts tx_data
//   dbg_a, dbg_di       register address and write data
//   dbg_we, dbg_rd      write / read strobe, held until dbg_ready
//   dbg_do, dbg_ready   read data and access-complete from the register file
//   busy                high whenever a command is in progress
//
// state | meaning
// IDLE  | waiting for an opcode byte
// ADDR  | waiting for the address byte
// DLO   | waiting for write data low byte
// DHI   | waiting for write data high byte
// BUS   | strobe high, waiting for dbg_ready or bus timeout
// RSP1  | presenting read data low byte
// RSP2  | presenting final response byte (ACK, NAK or read data high)

module debug_cmd_bridge #(
    parameter logic [15:0] BYTE_TIMEOUT = 16'd50000,
    parameter logic [7:0]  BUS_TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  dbg_a,
    output logic [15:0] dbg_di,
    output logic        dbg_we,
    output logic        dbg_rd,
    input  logic [15:0] dbg_do,
    input  logic        dbg_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DLO, S_DHI, S_BUS, S_RSP1, S_RSP2
    } state_t;

    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    state_t      state_q, state_d;
    logic        op_wr_q, op_wr_d;
    logic [7:0]  tx_data_d;
    logic        tx_valid_d;
    logic [7:0]  dbg_a_d;
    logic [15:0] dbg_di_d;
    logic        dbg_we_d, dbg_rd_d;
    // Only the high read byte needs holding: the low byte is loaded straight
    // into tx_data in the capture cycle and sits there until handshaken.
    logic [7:0]  hold_hi_q, hold_hi_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  bus_cnt_q, bus_cnt_d;
    logic        byte_to;

    // Byte timer counts down from BYTE_TIMEOUT; reaching zero means the host
    // has been silent for BYTE_TIMEOUT cycles in the current state.
    assign byte_to = (BYTE_TIMEOUT != 16'd0) && (byte_cnt_q == 16'd0);

    always_comb begin
        state_d    = state_q;
        op_wr_d    = op_wr_q;
        tx_data_d  = tx_data;
        tx_valid_d = tx_valid;
        dbg_a_d    = dbg_a;
        dbg_di_d   = dbg_di;
        dbg_we_d   = dbg_we;
        dbg_rd_d   = dbg_rd;
        hold_hi_d  = hold_hi_q;
        byte_cnt_d = byte_cnt_q;
        bus_cnt_d  = bus_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_WR || rx_data == OP_RD) begin
                        op_wr_d    = (rx_data == OP_WR);
                        byte_cnt_d = BYTE_TIMEOUT;
                        state_d    = S_ADDR;
                    end else begin
                        tx_data_d  = NAK;
                        tx_valid_d = 1'b1;
                        state_d    = S_RSP2;
                    end
                end
            end
            S_ADDR, S_DLO, S_DHI: begin
                // Timeout wins over a byte arriving in the same cycle.
                if (byte_to) begin
                    state_d = S_IDLE;
                end else if (rx_valid) begin
                    byte_cnt_d = BYTE_TIMEOUT;
                    if (state_q == S_ADDR) begin
                        dbg_a_d = rx_data;
                    end else if (state_q == S_DLO) begin
                        dbg_di_d[7:0] = rx_data;
                    end else begin
                        dbg_di_d[15:8] = rx_data;
                    end
                    if (state_q == S_ADDR && op_wr_q) begin
                        state_d = S_DLO;
                    end else if (state_q == S_DLO) begin
                        state_d = S_DHI;
                    end else begin
                        state_d   = S_BUS;
                        dbg_we_d  = op_wr_q;
                        dbg_rd_d  = !op_wr_q;
                        bus_cnt_d = BUS_TIMEOUT - 8'd1;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q - 16'd1;
                end
            end
            S_BUS: begin
                if (dbg_ready) begin
                    dbg_we_d   = 1'b0;
                    dbg_rd_d   = 1'b0;
                    tx_valid_d = 1'b1;
                    if (op_wr_q) begin
                        tx_data_d = ACK;
                        state_d   = S_RSP2;
                    end else begin
                        tx_data_d = dbg_do[7:0];
                        hold_hi_d = dbg_do[15:8];
                        state_d   = S_RSP1;
                    end
                end else if (bus_cnt_q == 8'd0) begin
                    dbg_we_d   = 1'b0;
                    dbg_rd_d   = 1'b0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = NAK;
                    state_d    = S_RSP2;
                end else begin
                    bus_cnt_d = bus_cnt_q - 8'd1;
                end
            end
            S_RSP1: begin
                if (tx_ready) begin
                    tx_data_d = hold_hi_q;
                    state_d   = S_RSP2;
                end
            end
            S_RSP2: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_wr_q    <= 1'b0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            dbg_a      <= 8'h00;
            dbg_di     <= 16'h0000;
            dbg_we     <= 1'b0;
            dbg_rd     <= 1'b0;
            hold_hi_q  <= 8'h00;
            byte_cnt_q <= 16'd0;
            bus_cnt_q  <= 8'd0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_wr_q    <= op_wr_d;
            tx_data    <= tx_data_d;
            tx_valid   <= tx_valid_d;
            dbg_a      <= dbg_a_d;
            dbg_di     <= dbg_di_d;
            dbg_we     <= dbg_we_d;
            dbg_rd     <= dbg_rd_d;
            hold_hi_q  <= hold_hi_d;
            byte_cnt_q <= byte_cnt_d;
            bus_cnt_q  <= bus_cnt_d;
            busy       <= (state_d != S_IDLE);
        end
    end

endmodule
